// File: rtl/qk_seq_pkg.sv
// Shared types and instruction-bus bit positions for the QK instruction sequencer.
package qk_seq_pkg;

   localparam int INST_W   = 19;
   localparam int ADD_W    = 4;

   localparam int DIV      = 18;
   localparam int ACC      = 17;
   localparam int OFIFO_RD = 16;
   localparam int QK_ADD   = 12;   // qkmem_add occupies [15:12]
   localparam int PM_ADD   = 8;    // pmem_add occupies [11:8]
   localparam int EXECUTE  = 7;
   localparam int LOAD     = 6;
   localparam int QMEM_RD  = 5;
   localparam int QMEM_WR  = 4;
   localparam int KMEM_RD  = 3;
   localparam int KMEM_WR  = 2;
   localparam int PMEM_RD  = 1;
   localparam int PMEM_WR  = 0;

   typedef enum logic [3:0] {
      S_IDLE, S_QWR, S_KWR, S_G1, S_KLOAD, S_G2,
      S_EXEC, S_G3, S_ACC, S_G4, S_NORM, S_DONE
   } state_t;

endpackage

// File: rtl/phase_counter.sv
// Clear-on-entry, enable-gated up counter with terminal-count compare.
// The next count is exported so the owner can register outputs that line up
// with the counter value of the cycle they appear in.
module phase_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] term,
   output logic [W-1:0] count_next,
   output logic         hit
);

   logic [W-1:0] count;

   // clear wins over enable so a phase always starts at zero
   always_comb begin
      count_next = count;
      if (clr)
         count_next = '0;
      else if (en)
         count_next = count + W'(1);
   end

   // count register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         count <= '0;
      else
         count <= count_next;
   end

   assign hit = (count == term);

endmodule

// File: rtl/qk_inst_sequencer.sv
// One-shot instruction sequencer for a single attention core: Q/K write,
// K load, execute, accumulate and normalize, launched by a start pulse.
module qk_inst_sequencer
   import qk_seq_pkg::*;
#(
   parameter int total_cycle = 8,
   parameter int col         = 8,
   parameter int gap         = 10,
   parameter int aw          = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic              busy,
   output logic              done,
   output logic [INST_W-1:0] inst
);

   // counter must reach the longest phase: col+2, total_cycle+1 or gap
   localparam int M1   = (col + 2 > total_cycle + 1) ? col + 2 : total_cycle + 1;
   localparam int MAXC = (M1 > gap) ? M1 : gap;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [CW-1:0] T_TC1  = CW'(total_cycle - 1);
   localparam logic [CW-1:0] T_COL1 = CW'(col - 1);
   localparam logic [CW-1:0] T_GAP1 = CW'(gap - 1);
   localparam logic [CW-1:0] T_KL   = CW'(col + 1);
   localparam logic [CW-1:0] T_NORM = CW'(total_cycle);
   localparam logic [CW-1:0] T_COL  = CW'(col);
   localparam logic [ADD_W-1:0] A_MASK = ADD_W'((1 << aw) - 1);

   state_t            state, state_n;
   logic [CW-1:0]     c_next, term;
   logic              hit, en, clr;
   logic [INST_W-1:0] inst_q, wr_bits;

   phase_counter #(.W(CW)) u_cnt (
      .clk        (clk),
      .reset      (reset),
      .clr        (clr),
      .en         (en),
      .term       (term),
      .count_next (c_next),
      .hit        (hit)
   );

   function automatic logic [ADD_W-1:0] addr(input logic [CW-1:0] k);
      logic [ADD_W-1:0] a;
      a = ADD_W'(k);
      return a & A_MASK;
   endfunction

   // instruction word seen while in state s with phase count k
   function automatic logic [INST_W-1:0] decode(input state_t s, input logic [CW-1:0] k);
      logic [INST_W-1:0] v;
      v = '0;
      case (s)
         S_QWR, S_KWR: v[QK_ADD +: ADD_W] = addr(k);
         S_KLOAD: begin
            v[LOAD] = 1'b1;
            if (k != '0 && k <= T_COL) begin
               v[KMEM_RD]           = 1'b1;
               v[QK_ADD +: ADD_W]   = addr(k - CW'(1));
            end
         end
         S_EXEC: begin
            v[EXECUTE]         = 1'b1;
            v[QMEM_RD]         = 1'b1;
            v[QK_ADD +: ADD_W] = addr(k);
         end
         S_ACC: begin
            v[OFIFO_RD] = 1'b1;
            v[ACC]      = 1'b1;
         end
         S_NORM: begin
            v[DIV] = 1'b1;
            if (k != '0) begin
               v[PMEM_WR]         = 1'b1;
               v[PM_ADD +: ADD_W] = addr(k - CW'(1));
            end
         end
         default: v = '0;
      endcase
      return v;
   endfunction

   // next state, phase terminal count and counter enable; abort overrides all
   always_comb begin
      state_n = state;
      term    = '0;
      en      = 1'b1;
      case (state)
         S_IDLE: begin
            en = 1'b0;
            if (start) state_n = S_QWR;
         end
         S_QWR: begin
            en   = wr_valid;
            term = T_TC1;
            if (wr_valid && hit) state_n = S_KWR;
         end
         S_KWR: begin
            en   = wr_valid;
            term = T_COL1;
            if (wr_valid && hit) state_n = S_G1;
         end
         S_G1: begin
            term = T_GAP1;
            if (hit) state_n = S_KLOAD;
         end
         S_KLOAD: begin
            term = T_KL;
            if (hit) state_n = S_G2;
         end
         S_G2: begin
            term = T_GAP1;
            if (hit) state_n = S_EXEC;
         end
         S_EXEC: begin
            term = T_TC1;
            if (hit) state_n = S_G3;
         end
         S_G3: begin
            term = T_GAP1;
            if (hit) state_n = S_ACC;
         end
         S_ACC: begin
            term = T_TC1;
            if (hit) state_n = S_G4;
         end
         S_G4: begin
            term = T_TC1;
            if (hit) state_n = S_NORM;
         end
         S_NORM: begin
            term = T_NORM;
            if (hit) state_n = S_DONE;
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      if (abort) state_n = S_IDLE;
   end

   assign clr = (state_n != state);

   // state and registered instruction word, decoded from the upcoming state/count
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         inst_q <= '0;
      end else begin
         state  <= state_n;
         inst_q <= decode(state_n, c_next);
      end
   end

   // write strobes follow wr_valid directly so an accepted beat is same-cycle
   always_comb begin
      wr_bits          = '0;
      wr_bits[QMEM_WR] = wr_valid & (state == S_QWR);
      wr_bits[KMEM_WR] = wr_valid & (state == S_KWR);
   end

   assign inst     = inst_q | wr_bits;
   assign wr_ready = (state == S_QWR) || (state == S_KWR);
   assign busy     = (state != S_IDLE);
   assign done     = (state == S_DONE);

endmodule
